// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and the ALU:
// ALU control codes, instruction field encodings and the controller state set.
package mips_pkg;

    // ALU control codes (shared with the ALU block)
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1100;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    // Controller states; 4'hC..4'hF are unused encodings
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_I_EXEC   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // True when funct names an R-type operation the datapath supports
    function automatic logic is_rtype_funct(input logic [5:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_mc_control_alu_op_decode.sv
// Combinational ALU operation selector: maps controller state plus
// instruction fields onto the 4-bit ALU control code.
module alu_op_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    // Select ALU operation; states that do not use the ALU drive 4'b0000
    always_comb begin
        alu_control = 4'b0000;
        case (state)
            S_FETCH, S_DECODE, S_MEM_ADDR: alu_control = ALU_ADD;
            S_BRANCH:                      alu_control = ALU_SUB;
            S_R_EXEC: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_XOR:  alu_control = ALU_XOR;
                    FN_SLL:  alu_control = ALU_SLL;
                    FN_SRL:  alu_control = ALU_SRL;
                    default: alu_control = 4'b0000;
                endcase
            end
            S_I_EXEC: begin
                case (opcode)
                    OP_ADDI: alu_control = ALU_ADD;
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    OP_XORI: alu_control = ALU_XOR;
                    default: alu_control = 4'b0000;
                endcase
            end
            default: alu_control = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit. Walks each instruction through fetch,
// decode, execute, memory and writeback, driving datapath selects and
// write enables, and counts retired instructions.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [3:0]           alu_control,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 illegal_op,
    output logic [RET_CNT_W-1:0] retired,
    output logic [3:0]           state
);

    state_t               state_r;
    state_t               next_state_s;
    logic                 retire_s;
    logic [RET_CNT_W-1:0] retired_r;
    logic                 zero_unused_s;

    // Branch resolution happens in the datapath, which gates pc_write_cond with zero
    assign zero_unused_s = zero;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_r <= '0;
        end else if (retire_s) begin
            retired_r <= retired_r + {{(RET_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state and control strobe decode; every strobe defaults low
    always_comb begin
        next_state_s  = S_FETCH;
        retire_s      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (is_rtype_funct(funct)) begin
                            next_state_s = S_R_EXEC;
                        end else begin
                            next_state_s = S_FETCH;
                            illegal_op   = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:                      next_state_s = S_MEM_ADDR;
                    OP_BEQ:                            next_state_s = S_BRANCH;
                    OP_J:                              next_state_s = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: next_state_s = S_I_EXEC;
                    default: begin
                        next_state_s = S_FETCH;
                        illegal_op   = 1'b1;
                    end
                endcase
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b00;
                next_state_s = S_R_WB;
            end
            S_R_WB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                next_state_s = S_I_WB;
            end
            S_I_WB: begin
                reg_write    = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    next_state_s = S_MEM_RD;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire_s      = 1'b1;
                next_state_s  = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = 2'b10;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .state       (state_r),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (alu_control)
    );

    assign retired = retired_r;
    assign state   = state_r;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS control unit: the producer side of the ALU's 4-bit control interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the ALU operation code, datapath mux selects and register/memory/PC write enables.
- Sits between the instruction register and the shared datapath (register file, ALU, memory, PC).

Parameters:
- RET_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH and clears counter.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in a cycle with mem_ready=1.
- alu_control  out  4  ALU op: 0010 add, 0110 sub, 0000 and, 0001 or, 1001 xor, 1010 sll, 1100 srl.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  IR load enable.
- pc_write, pc_write_cond  out  1 each  PC enables.
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode/funct.
- retired  out  RET_CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- State register updates on posedge clk; async reset sets FETCH. All outputs are decoded from state, opcode and funct; an output not listed for a state is 0.
- Reset outputs: FETCH decode (mem_read=1, alu_src_b=01, alu_control=0010), retired=0, illegal_op=0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=0010.
  - While mem_ready=0: stay in FETCH, ir_write=0, pc_write=0.
  - In the mem_ready=1 cycle: ir_write=1, pc_write=1, pc_source=00, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_control=0010 (branch target into ALUOut).
  - Transitions by opcode:
    - 0x00 with funct in {0x20,0x22,0x24,0x25,0x26,0x00,0x02} -> R_EXEC.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x08, 0x0C, 0x0D, 0x0E -> I_EXEC.
    - Anything else -> FETCH with illegal_op=1 for that cycle; retired does not increment.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_control from funct: 20->0010, 22->0110, 24->0000, 25->0001, 26->1001, 00->1010, 02->1100. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_control: 08->0010, 0C->0000, 0D->0001, 0E->1001. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=0010. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=0110, pc_write_cond=1, pc_source=01. Next FETCH. The datapath gates the PC write with zero; the controller ignores zero.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- retired increments by 1 on every transition into FETCH except the illegal path. Wraps modulo 2^RET_CNT_W.
- Reset mid-instruction: next cycle is FETCH. No write strobe is asserted after reset deassertion until FETCH completes.
- Encoding 4'hF is unused; if reached, the next state is FETCH.

Decomposition:
- Shared package mips_pkg: ALU control code constants, opcode and funct constants, state enum (4-bit).
- ALU control constants are shared with the ALU block.
- Sub-module alu_op_decode (combinational: state, opcode, funct -> alu_control) is instantiated once.

Test Plan:
- add (op 00, funct 20) with mem_ready tied 1 -> states FETCH, DECODE, R_EXEC, R_WB; alu_control=0010 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB; retired=1 after 4 cycles.
- lw (op 23) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB asserts mem_to_reg=1 and reg_write=1; total 5+3=8 cycles.
- beq (op 04) -> BRANCH asserts alu_control=0110, pc_write_cond=1, pc_source=01; 3 cycles; sll (funct 00) -> alu_control=1010 in R_EXEC.
- opcode 0x3F -> illegal_op pulses in the DECODE cycle, next state is FETCH, retired unchanged.
- reset asserted in MEM_WR -> state=FETCH immediately (asynchronous), mem_write=0, retired=0.
- RET_CNT_W=4: 16 jumps (op 02, 3 cycles each) -> retired wraps to 0.
